// File: rtl/mem_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_responder
// Brief    : Memory-side bus responder. Accepts one read/write request at a
//            time via valid/ready, waits LATENCY cycles, then returns a
//            single-cycle response with read data and an error flag.
//            Word-organised storage with word/half/byte writes.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int         c_DEPTH = 1 << ADDR_W;
  localparam logic [3:0] c_LAT   = 4'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;
  logic        r_busy;

  // Latched request fields
  logic        r_write;
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic [31:0] r_wdata;

  logic [31:0] r_mem [c_DEPTH];

  // With zero latency the access happens on the acceptance edge itself, so
  // the live request fields are used there; otherwise the latched copies.
  logic              w_accept;
  logic              w_enter_resp;
  logic              w_acc_write;
  logic [31:0]       w_acc_addr;
  logic [1:0]        w_acc_size;
  logic [31:0]       w_acc_wdata;
  logic              w_err;
  logic [ADDR_W-1:0] w_idx;
  logic [3:0]        w_bmask;
  logic [31:0]       w_wword;

  assign w_accept     = (r_state == S_IDLE) && req_valid;
  assign w_enter_resp = (w_accept && (c_LAT == 4'd0)) ||
                        ((r_state == S_WAIT) && (r_cnt == 4'd1));

  assign w_acc_write = (r_state == S_IDLE) ? req_write : r_write;
  assign w_acc_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
  assign w_acc_size  = (r_state == S_IDLE) ? req_size  : r_size;
  assign w_acc_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;

  assign w_idx = w_acc_addr[ADDR_W+1:2];

  // Error decode: illegal size, misalignment, or address beyond storage
  always_comb begin
    w_err = 1'b0;
    if (w_acc_size == 2'b11)                              w_err = 1'b1;
    if ((w_acc_size == 2'b00) && (w_acc_addr[1:0] != 2'b00)) w_err = 1'b1;
    if ((w_acc_size == 2'b01) && w_acc_addr[0])           w_err = 1'b1;
    if ((w_acc_addr >> (ADDR_W + 2)) != 32'd0)            w_err = 1'b1;
  end

  // Byte-lane enables and lane-replicated write data (little-endian lanes)
  always_comb begin
    w_bmask = 4'b0000;
    w_wword = w_acc_wdata;
    case (w_acc_size)
      2'b00: w_bmask = 4'b1111;
      2'b01: begin
        w_bmask = w_acc_addr[1] ? 4'b1100 : 4'b0011;
        w_wword = {w_acc_wdata[15:0], w_acc_wdata[15:0]};
      end
      2'b10: begin
        w_bmask = 4'b0001 << w_acc_addr[1:0];
        w_wword = {4{w_acc_wdata[7:0]}};
      end
      default: w_bmask = 4'b0000;
    endcase
  end

  // Control FSM: handshake, wait counter and registered response outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
      r_busy       <= 1'b0;
      r_write      <= 1'b0;
      r_addr       <= 32'd0;
      r_size       <= 2'b00;
      r_wdata      <= 32'd0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write     <= req_write;
            r_addr      <= req_addr;
            r_size      <= req_size;
            r_wdata     <= req_wdata;
            r_cnt       <= c_LAT;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= (c_LAT == 4'd0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd1) begin
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase

      if (w_enter_resp) begin
        r_resp_valid <= 1'b1;
        r_resp_err   <= w_err;
        if (w_err) begin
          r_resp_rdata <= 32'd0;
        end else if (!w_acc_write) begin
          r_resp_rdata <= r_mem[w_idx];
        end
      end
    end
  end

  // Storage: cleared on reset, lane-masked write on the edge entering RESP
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_mem[i] <= 32'd0;
      end
    end else if (w_enter_resp && w_acc_write && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_bmask[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
        end
      end
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_responder
// Brief    : Directed self-checking bench for mem_bus_responder. One instance
//            with LATENCY=2 for functional tests, one with LATENCY=0 for
//            back-to-back handshake timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_responder;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_valid1;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;

  logic        req_ready,  resp_valid,  resp_err,  busy;
  logic [31:0] resp_rdata;
  logic        req_ready1, resp_valid1, resp_err1, busy1;
  logic [31:0] resp_rdata1;

  int n_cmp;
  int n_err;

  mem_bus_responder #(.ADDR_W(8), .LATENCY(2)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  mem_bus_responder #(.ADDR_W(8), .LATENCY(0)) u_dut_l0 (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid1),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready1),
    .resp_valid (resp_valid1),
    .resp_rdata (resp_rdata1),
    .resp_err   (resp_err1),
    .busy       (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One transaction on the LATENCY=2 instance. Called at a negedge with the
  // DUT idle; returns at a negedge with the DUT idle again. Inputs are
  // scrambled after acceptance so only latched fields can matter.
  task automatic xact(input string tag, input logic w, input logic [31:0] a,
                      input logic [1:0] s, input logic [31:0] d,
                      output logic [31:0] rd, output logic er,
                      output int lat, output int bcnt);
    check_eq({tag, " ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_size  = s;
    req_wdata = d;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_write = ~w;
    req_addr  = 32'hFFFF_FFFF;
    req_size  = 2'b11;
    req_wdata = ~d;
    lat  = 0;
    bcnt = 0;
    while (!resp_valid && lat < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s timeout: got no resp_valid expected resp_valid=1", tag);
    end
    if (busy) bcnt++;
    check_eq({tag, " ready@resp"}, 32'(req_ready), 32'd0);
    rd = resp_rdata;
    er = resp_err;
    @(negedge clk);
    check_eq({tag, " valid after"}, 32'(resp_valid), 32'd0);
    check_eq({tag, " err after"},   32'(resp_err),   32'd0);
    check_eq({tag, " busy after"},  32'(busy),       32'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          bc;

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_valid1 = 1'b0;
    req_write  = 1'b0;
    req_addr   = 32'd0;
    req_size   = 2'b00;
    req_wdata  = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    check_eq("rst ready", 32'(req_ready),  32'd1);
    check_eq("rst valid", 32'(resp_valid), 32'd0);
    check_eq("rst rdata", resp_rdata,      32'd0);
    check_eq("rst err",   32'(resp_err),   32'd0);
    check_eq("rst busy",  32'(busy),       32'd0);

    // Word write, latency and busy duration
    xact("wr10", 1'b1, 32'h10, 2'b00, 32'hDEAD_BEEF, rd, er, lat, bc);
    check_eq("wr10 lat",  32'(lat), 32'd2);
    check_eq("wr10 busy", 32'(bc),  32'd3);
    check_eq("wr10 err",  32'(er),  32'd0);
    check_eq("wr10 rd",   rd,       32'd0);

    xact("rd10a", 1'b0, 32'h10, 2'b00, 32'h0, rd, er, lat, bc);
    check_eq("rd10a rd",  rd,      32'hDEAD_BEEF);
    check_eq("rd10a err", 32'(er), 32'd0);

    // Byte write lane 2; write response holds previous read data
    xact("wb12", 1'b1, 32'h12, 2'b10, 32'h0000_00AA, rd, er, lat, bc);
    check_eq("wb12 rd hold", rd,      32'hDEAD_BEEF);
    check_eq("wb12 err",     32'(er), 32'd0);
    xact("rd10b", 1'b0, 32'h10, 2'b00, 32'h0, rd, er, lat, bc);
    check_eq("rd10b rd", rd, 32'hDEAA_BEEF);

    // Half write upper half
    xact("wh12", 1'b1, 32'h12, 2'b01, 32'h0000_1234, rd, er, lat, bc);
    check_eq("wh12 err", 32'(er), 32'd0);
    xact("rd10c", 1'b0, 32'h10, 2'b00, 32'h0, rd, er, lat, bc);
    check_eq("rd10c rd", rd, 32'h1234_BEEF);

    // Misaligned half write: error, no update, rdata zeroed
    xact("wh11", 1'b1, 32'h11, 2'b01, 32'h0000_5678, rd, er, lat, bc);
    check_eq("wh11 err", 32'(er), 32'd1);
    check_eq("wh11 rd",  rd,      32'd0);
    xact("rd10d", 1'b0, 32'h10, 2'b00, 32'h0, rd, er, lat, bc);
    check_eq("rd10d rd",  rd,      32'h1234_BEEF);
    check_eq("rd10d err", 32'(er), 32'd0);

    // Error reads: misaligned word, out of range, illegal size
    xact("rd402", 1'b0, 32'h402, 2'b00, 32'h0, rd, er, lat, bc);
    check_eq("rd402 err", 32'(er), 32'd1);
    check_eq("rd402 rd",  rd,      32'd0);
    xact("rd10e", 1'b0, 32'h10, 2'b00, 32'h0, rd, er, lat, bc);
    xact("rd400", 1'b0, 32'h400, 2'b00, 32'h0, rd, er, lat, bc);
    check_eq("rd400 err", 32'(er), 32'd1);
    check_eq("rd400 rd",  rd,      32'd0);
    xact("rd10f", 1'b0, 32'h10, 2'b00, 32'h0, rd, er, lat, bc);
    xact("rdsz3", 1'b0, 32'h10, 2'b11, 32'h0, rd, er, lat, bc);
    check_eq("rdsz3 err", 32'(er), 32'd1);
    check_eq("rdsz3 rd",  rd,      32'd0);

    // Zero latency, req_valid held: RESP and IDLE alternate
    req_write  = 1'b0;
    req_addr   = 32'h0;
    req_size   = 2'b00;
    req_valid1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq($sformatf("l0 valid%0d", i), 32'(resp_valid1), 32'(i % 2 == 0));
      check_eq($sformatf("l0 ready%0d", i), 32'(req_ready1),  32'(i % 2 == 1));
      check_eq($sformatf("l0 busy%0d",  i), 32'(busy1),       32'(i % 2 == 0));
      check_eq($sformatf("l0 rd%0d",    i), resp_rdata1,      32'd0);
      check_eq($sformatf("l0 err%0d",   i), 32'(resp_err1),   32'd0);
    end
    req_valid1 = 1'b0;
    @(negedge clk);

    // Reset during WAIT aborts the write and clears storage
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h20;
    req_size  = 2'b00;
    req_wdata = 32'h5555_AAAA;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("abort busy", 32'(busy), 32'd1);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq($sformatf("abort valid%0d", i), 32'(resp_valid), 32'd0);
    end
    reset = 1'b0;
    check_eq("abort ready", 32'(req_ready), 32'd1);
    xact("rd20", 1'b0, 32'h20, 2'b00, 32'h0, rd, er, lat, bc);
    check_eq("rd20 rd",  rd,      32'd0);
    check_eq("rd20 err", 32'(er), 32'd0);
    xact("rd10g", 1'b0, 32'h10, 2'b00, 32'h0, rd, er, lat, bc);
    check_eq("rd10g rd", rd, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
